// File: rtl/sram_arb_if.sv
// Bundles the two requester ports, the SRAM controller port and the abort flag of sram_arb.
// The arbiter connects to the slave modport; a requester/controller environment uses master.
interface sram_arb_if;
  logic        a_req;
  logic        a_we;
  logic        a_be;
  logic [20:0] a_addr;
  logic [31:0] a_wdata;
  logic [31:0] a_rdata;
  logic        a_ack;

  logic        b_req;
  logic        b_we;
  logic        b_be;
  logic [20:0] b_addr;
  logic [31:0] b_wdata;
  logic [31:0] b_rdata;
  logic        b_ack;

  logic        m_en;
  logic        m_we;
  logic        m_be;
  logic [20:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_rdy;
  logic        tmo_err;

  modport slave (
    input  a_req, a_we, a_be, a_addr, a_wdata,
    output a_rdata, a_ack,
    input  b_req, b_we, b_be, b_addr, b_wdata,
    output b_rdata, b_ack,
    output m_en, m_we, m_be, m_addr, m_wdata,
    input  m_rdata, m_rdy,
    output tmo_err
  );

  modport master (
    output a_req, a_we, a_be, a_addr, a_wdata,
    input  a_rdata, a_ack,
    output b_req, b_we, b_be, b_addr, b_wdata,
    input  b_rdata, b_ack,
    input  m_en, m_we, m_be, m_addr, m_wdata,
    output m_rdata, m_rdy,
    input  tmo_err
  );
endinterface

// File: rtl/sram_arb.sv
// Two-port (CPU = A, DMA = B) arbiter in front of a single SRAM controller, with
// A-priority bounded by a starvation counter and a per-transfer ready timeout.
module sram_arb #(
  parameter int STARVE_MAX = 4,
  parameter int TMO_CYC    = 15
) (
  input logic       clk,
  input logic       rst_n,
  sram_arb_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [SW-1:0] starve_r, starve_s;
  logic [3:0]    tmo_r, tmo_s;
  logic          grant_b_r, grant_b_s;
  logic          grant_s;
  logic          capture_s;
  logic          timeout_s;

  logic          we_r;
  logic          be_r;
  logic [20:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   a_rdata_r;
  logic [31:0]   b_rdata_r;
  logic          m_en_r;
  logic          a_ack_r;
  logic          b_ack_r;
  logic          tmo_err_r;

  // Next-state, arbitration and counter update logic
  always_comb begin
    state_s   = state_r;
    starve_s  = starve_r;
    tmo_s     = tmo_r;
    grant_b_s = grant_b_r;
    grant_s   = 1'b0;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if ((bus.a_req || bus.b_req) && bus.m_rdy) begin
          grant_s   = 1'b1;
          grant_b_s = !bus.a_req || (bus.b_req && (starve_r == SW'(STARVE_MAX)));
          // Starvation only accumulates while B is actually kept waiting by A
          if (grant_b_s || !bus.b_req) begin
            starve_s = {SW{1'b0}};
          end else if (starve_r != SW'(STARVE_MAX)) begin
            starve_s = starve_r + SW'(1);
          end else begin
            starve_s = starve_r;
          end
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        tmo_s   = 4'd0;
        state_s = WAIT;
      end
      WAIT: begin
        if (bus.m_rdy) begin
          capture_s = !we_r;
          state_s   = DONE;
        end else if (({1'b0, tmo_r} + 5'd1) == 5'(TMO_CYC)) begin
          timeout_s = 1'b1;
          tmo_s     = tmo_r + 4'd1;
          state_s   = DONE;
        end else begin
          tmo_s   = tmo_r + 4'd1;
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and granted-port register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      starve_r  <= {SW{1'b0}};
      tmo_r     <= 4'd0;
      grant_b_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      starve_r  <= starve_s;
      tmo_r     <= tmo_s;
      grant_b_r <= grant_b_s;
    end
  end

  // Transfer qualifiers captured at grant so requester changes cannot disturb the transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      be_r    <= 1'b0;
      addr_r  <= 21'd0;
      wdata_r <= 32'd0;
    end else if (grant_s) begin
      we_r    <= grant_b_s ? bus.b_we    : bus.a_we;
      be_r    <= grant_b_s ? bus.b_be    : bus.a_be;
      addr_r  <= grant_b_s ? bus.b_addr  : bus.a_addr;
      wdata_r <= grant_b_s ? bus.b_wdata : bus.a_wdata;
    end
  end

  // Per-port read data, updated only by a successful read on that port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_r <= 32'd0;
      b_rdata_r <= 32'd0;
    end else if (capture_s) begin
      if (grant_b_r) begin
        b_rdata_r <= bus.m_rdata;
      end else begin
        a_rdata_r <= bus.m_rdata;
      end
    end
  end

  // Strobes registered from the next state so each is high for exactly its state's cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en_r    <= 1'b0;
      a_ack_r   <= 1'b0;
      b_ack_r   <= 1'b0;
      tmo_err_r <= 1'b0;
    end else begin
      m_en_r    <= (state_s == ISSUE);
      a_ack_r   <= (state_s == DONE) && !grant_b_s;
      b_ack_r   <= (state_s == DONE) && grant_b_s;
      tmo_err_r <= timeout_s;
    end
  end

  assign bus.m_en    = m_en_r;
  assign bus.m_we    = we_r;
  assign bus.m_be    = be_r;
  assign bus.m_addr  = addr_r;
  assign bus.m_wdata = wdata_r;
  assign bus.a_rdata = a_rdata_r;
  assign bus.b_rdata = b_rdata_r;
  assign bus.a_ack   = a_ack_r;
  assign bus.b_ack   = b_ack_r;
  assign bus.tmo_err = tmo_err_r;

endmodule

// File: tb/tb_sram_arb.sv
// Randomized bench for sram_arb: a transaction-level arbitration model feeds expectation
// queues that an independent monitor drains; a behavioural SRAM controller answers m_en.
module tb_sram_arb;
  localparam int STARVE_MAX = 4;
  localparam int TMO_CYC    = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sram_arb_if bus();

  sram_arb #(.STARVE_MAX(STARVE_MAX), .TMO_CYC(TMO_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port_b;
    logic        we;
    logic        be;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic        tmo;
    logic [31:0] a_rd;
    logic [31:0] b_rd;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] data;
  } rsp_t;

  exp_t mq[$];
  exp_t aq[$];
  rsp_t rq[$];

  int checks   = 0;
  int failures = 0;

  // transaction-level model state
  bit          pa = 1'b0;
  bit          pb = 1'b0;
  int          starve = 0;
  logic [31:0] a_last = 32'd0;
  logic [31:0] b_last = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Controller: busy for 'lat' cycles after each m_en, then returns data with m_rdy
  int          c_cnt;
  logic [31:0] c_data;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_rdy   <= 1'b1;
      bus.m_rdata <= 32'd0;
      c_cnt       <= 0;
      c_data      <= 32'd0;
    end else if (bus.m_en) begin
      bus.m_rdy <= 1'b0;
      if (rq.size() > 0) begin
        c_cnt  <= rq[0].lat;
        c_data <= rq[0].data;
        rq.delete(0);
      end else begin
        c_cnt  <= 1;
        c_data <= 32'd0;
      end
    end else if (!bus.m_rdy) begin
      if (c_cnt > 1) begin
        c_cnt <= c_cnt - 1;
      end else begin
        bus.m_rdy   <= 1'b1;
        bus.m_rdata <= c_data;
      end
    end
  end

  // Monitor: issue fields checked on m_en and held until ack; ack checked against scoreboard
  initial begin
    exp_t cur;
    exp_t e;
    bit   active;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else begin
        if (bus.m_en) begin
          if (active) begin
            checks++;
            failures++;
            $display("FAIL m_en_extra actual=1 required=0");
          end else if (mq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL m_en_unexpected actual=1 required=0");
          end else begin
            cur    = mq.pop_front();
            active = 1'b1;
          end
        end
        if (active) begin
          check("m_we",    64'(bus.m_we),    64'(cur.we));
          check("m_be",    64'(bus.m_be),    64'(cur.be));
          check("m_addr",  64'(bus.m_addr),  64'(cur.addr));
          check("m_wdata", 64'(bus.m_wdata), 64'(cur.wdata));
        end
        if (bus.a_ack || bus.b_ack) begin
          if (aq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ack_unexpected actual=%b%b required=00", bus.a_ack, bus.b_ack);
          end else begin
            e = aq.pop_front();
            check("ack_port", 64'({bus.a_ack, bus.b_ack}), 64'({!e.port_b, e.port_b}));
            check("a_rdata",  64'(bus.a_rdata), 64'(e.a_rd));
            check("b_rdata",  64'(bus.b_rdata), 64'(e.b_rd));
            check("tmo_err",  64'(bus.tmo_err), 64'(e.tmo));
          end
          active = 1'b0;
        end else if (bus.tmo_err) begin
          checks++;
          failures++;
          $display("FAIL tmo_without_ack actual=1 required=0");
        end
      end
    end
  end

  task automatic raise(input bit port_b, input logic we, input logic be,
                       input logic [20:0] addr, input logic [31:0] wdata);
    if (port_b) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_be = be; bus.b_addr = addr; bus.b_wdata = wdata;
      pb = 1'b1;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_be = be; bus.a_addr = addr; bus.a_wdata = wdata;
      pa = 1'b1;
    end
  endtask

  task automatic raise_rand(input bit port_b);
    raise(port_b, 1'($urandom), 1'($urandom), 21'($urandom), $urandom);
  endtask

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return TMO_CYC;
    if (r == 1) return TMO_CYC - 1;
    if (r == 2) return TMO_CYC + 5;
    return int'($urandom_range(1, 6));
  endfunction

  // One arbitration decision: predict winner, queue expectations, wait the transfer out
  task automatic serve(input int lat, input logic [31:0] data);
    exp_t e;
    rsp_t r;
    bit   win_b;
    bit   seen;
    win_b = !pa || (pb && (starve == STARVE_MAX));
    if (win_b || !pb) starve = 0;
    else if (starve < STARVE_MAX) starve = starve + 1;
    e.port_b = win_b;
    e.we     = win_b ? bus.b_we    : bus.a_we;
    e.be     = win_b ? bus.b_be    : bus.a_be;
    e.addr   = win_b ? bus.b_addr  : bus.a_addr;
    e.wdata  = win_b ? bus.b_wdata : bus.a_wdata;
    e.tmo    = (lat >= TMO_CYC);
    if (!e.we && !e.tmo) begin
      if (win_b) b_last = data;
      else a_last = data;
    end
    e.a_rd = a_last;
    e.b_rd = b_last;
    r.lat  = lat;
    r.data = data;
    rq.push_back(r);
    mq.push_back(e);
    aq.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = bus.m_en;
    end
    check("grant_wait", 64'(seen), 64'd1);
    if ($urandom_range(0, 1) == 1) begin
      if (win_b) begin
        bus.b_we = 1'($urandom); bus.b_be = 1'($urandom); bus.b_addr = 21'($urandom);
        bus.b_wdata = $urandom; bus.b_req = 1'($urandom);
      end else begin
        bus.a_we = 1'($urandom); bus.a_be = 1'($urandom); bus.a_addr = 21'($urandom);
        bus.a_wdata = $urandom; bus.a_req = 1'($urandom);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = bus.a_ack || bus.b_ack;
    end
    check("ack_wait", 64'(seen), 64'd1);
    if (win_b) begin
      bus.b_req = 1'b0; pb = 1'b0;
    end else begin
      bus.a_req = 1'b0; pa = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    rsp_t r;
    bit   seen;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_be = 1'b0; bus.a_addr = 21'd0; bus.a_wdata = 32'd0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_be = 1'b0; bus.b_addr = 21'd0; bus.b_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_m_en",    64'(bus.m_en),    64'd0);
    check("rst_acks",    64'({bus.a_ack, bus.b_ack, bus.tmo_err}), 64'd0);
    check("rst_m_we_be", 64'({bus.m_we, bus.m_be}), 64'd0);
    check("rst_m_addr",  64'(bus.m_addr),  64'd0);
    check("rst_m_wdata", 64'(bus.m_wdata), 64'd0);
    check("rst_rdata",   {bus.a_rdata, bus.b_rdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed: lone read, lone write, timeout with rdata retained
    raise(1'b0, 1'b0, 1'b0, 21'h00010, 32'd0);
    serve(4, 32'hDEADBEEF);
    raise(1'b1, 1'b1, 1'b1, 21'h00003, 32'h000000AA);
    serve(3, 32'h12345678);
    raise(1'b0, 1'b0, 1'b0, 21'h00055, 32'd0);
    serve(TMO_CYC + 5, 32'hCAFEF00D);

    // both ports requesting continuously: starvation bound governs the order
    for (int i = 0; i < 24; i++) begin
      if (!pa) raise_rand(1'b0);
      if (!pb) raise_rand(1'b1);
      serve(int'($urandom_range(1, 5)), $urandom);
    end

    // random traffic
    for (int i = 0; i < 120; i++) begin
      if (!pa && $urandom_range(0, 1) == 1) raise_rand(1'b0);
      if (!pb && $urandom_range(0, 2) == 0) raise_rand(1'b1);
      if (!pa && !pb) raise_rand(1'($urandom));
      serve(pick_lat(), $urandom);
    end
    while (pa || pb) serve(2, $urandom);

    // reset asserted mid-WAIT, then the still-pending A read must be served normally
    raise(1'b0, 1'b0, 1'b0, 21'h00077, 32'd0);
    e.port_b = 1'b0; e.we = 1'b0; e.be = 1'b0; e.addr = 21'h00077; e.wdata = 32'd0;
    e.tmo = 1'b0; e.a_rd = a_last; e.b_rd = b_last;
    mq.push_back(e);
    r.lat = TMO_CYC + 5;
    r.data = 32'h0BADF00D;
    rq.push_back(r);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = bus.m_en;
    end
    check("rst_grant_wait", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_en",  64'(bus.m_en), 64'd0);
    check("mid_rst_acks",  64'({bus.a_ack, bus.b_ack, bus.tmo_err}), 64'd0);
    check("mid_rst_m_bus", 64'({bus.m_we, bus.m_be, bus.m_addr}), 64'd0);
    check("mid_rst_wdata", 64'(bus.m_wdata), 64'd0);
    check("mid_rst_rdata", {bus.a_rdata, bus.b_rdata}, 64'd0);
    a_last = 32'd0;
    b_last = 32'd0;
    starve = 0;
    mq.delete();
    aq.delete();
    rq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    serve(3, $urandom);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
